// File: rtl/hilo_muldiv_pkg.sv
// rtl/hilo_muldiv_pkg.sv - op and state encodings shared by the HI/LO multiply/divide unit
package hilo_muldiv_pkg;

  typedef logic [1:0] muldiv_op_t;

  localparam muldiv_op_t MULDIV_MULT  = 2'b00;
  localparam muldiv_op_t MULDIV_MULTU = 2'b01;
  localparam muldiv_op_t MULDIV_DIV   = 2'b10;
  localparam muldiv_op_t MULDIV_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MULDIV_MULT) || (op == MULDIV_DIV);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == MULDIV_DIV) || (op == MULDIV_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// rtl/hilo_muldiv_if.sv - EX request / HI-LO writeback bundle of the multiply/divide unit
interface hilo_muldiv_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              flush;
  logic              busy;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;

  modport master (
    output req_valid, req_op, req_a, req_b, flush,
    input  req_ready, busy, wb_valid, wb_hi, wb_lo
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush,
    output req_ready, busy, wb_valid, wb_hi, wb_lo
  );
endinterface

// File: rtl/gnrl_dfflr.sv
// rtl/gnrl_dfflr.sv - generic load-enable flop with asynchronous active-high clear
module gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end
endmodule

// File: rtl/hilo_muldiv_signfix.sv
// rtl/hilo_muldiv_signfix.sv - operand magnitude on entry, sign correction of HI/LO on exit
module hilo_muldiv_signfix
  import hilo_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  muldiv_op_t          in_op,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  output logic                in_sign_a,
  output logic                in_sign_b,
  output logic [DATA_W-1:0]   in_abs_a,
  output logic [DATA_W-1:0]   in_abs_b,
  input  logic                res_is_div,
  input  logic                res_sign_a,
  input  logic                res_sign_b,
  input  logic                res_b_zero,
  input  logic [DATA_W-1:0]   res_raw_a,
  input  logic [2*DATA_W-1:0] res_acc,
  output logic [DATA_W-1:0]   res_hi,
  output logic [DATA_W-1:0]   res_lo
);
  // Sign flags are forced to 0 for unsigned ops, so the exit path needs no op decode.
  assign in_sign_a = op_is_signed(in_op) & in_a[DATA_W-1];
  assign in_sign_b = op_is_signed(in_op) & in_b[DATA_W-1];
  assign in_abs_a  = in_sign_a ? -in_a : in_a;
  assign in_abs_b  = in_sign_b ? -in_b : in_b;

  logic                neg;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;

  always_comb begin
    neg  = res_sign_a ^ res_sign_b;
    prod = neg ? -res_acc : res_acc;
    quo  = neg ? -res_acc[DATA_W-1:0] : res_acc[DATA_W-1:0];
    rem  = res_sign_a ? -res_acc[2*DATA_W-1:DATA_W] : res_acc[2*DATA_W-1:DATA_W];
    res_hi = prod[2*DATA_W-1:DATA_W];
    res_lo = prod[DATA_W-1:0];
    if (res_is_div) begin
      if (res_b_zero) begin
        res_hi = res_raw_a;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end
endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - 32-iteration MULT/MULTU/DIV/DIVU unit with one-cycle HI/LO writeback
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic          clk,
  input logic          rst,
  hilo_muldiv_if.slave bus
);
  localparam int ACC_W = 2 * DATA_W;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        info_q, info_d;
  logic              is_div_q, sign_a_q, sign_b_q, b_zero_q;
  logic [DATA_W-1:0] raw_a_q, b_abs_q;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_step;
  logic              wb_valid_q;
  logic [ACC_W-1:0]  wb_q;
  logic [DATA_W-1:0] fix_hi, fix_lo;
  logic              in_sign_a, in_sign_b;
  logic [DATA_W-1:0] in_abs_a, in_abs_b;
  logic              accept, calc, last, wb_load;

  assign accept  = bus.req_valid & bus.req_ready;
  assign calc    = (state_q == ST_CALC);
  assign last    = calc & (cnt_q == CNT_W'(DATA_W - 1));
  assign wb_load = last & ~bus.flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_CALC;
      ST_CALC: begin
        if (bus.flush)  state_d = ST_IDLE;
        else if (last)  state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The multiply carry bit of the {carry,hi,lo} accumulator is consumed by the same-cycle
  // shift, so only the 64 post-shift bits are stored.
  logic [DATA_W:0] mul_sum, rem_sh, rem_diff;
  logic            no_borrow;

  always_comb begin
    mul_sum   = {1'b0, acc_q[ACC_W-1:DATA_W]} + (acc_q[0] ? {1'b0, b_abs_q} : '0);
    rem_sh    = acc_q[ACC_W-1:DATA_W-1];
    rem_diff  = rem_sh - {1'b0, b_abs_q};
    no_borrow = ~rem_diff[DATA_W];
    if (is_div_q) begin
      acc_step = {(no_borrow ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0]),
                  acc_q[DATA_W-2:0], no_borrow};
    end else begin
      acc_step = {mul_sum, acc_q[DATA_W-1:1]};
    end
  end

  assign acc_d  = accept ? {{DATA_W{1'b0}}, in_abs_a} : acc_step;
  assign cnt_d  = accept ? '0 : cnt_q + 1'b1;
  assign info_d = {op_is_div(bus.req_op), in_sign_a, in_sign_b, (bus.req_b == '0)};
  assign {is_div_q, sign_a_q, sign_b_q, b_zero_q} = info_q;

  hilo_muldiv_signfix #(.DATA_W(DATA_W)) u_signfix (
    .in_op      (bus.req_op),
    .in_a       (bus.req_a),
    .in_b       (bus.req_b),
    .in_sign_a  (in_sign_a),
    .in_sign_b  (in_sign_b),
    .in_abs_a   (in_abs_a),
    .in_abs_b   (in_abs_b),
    .res_is_div (is_div_q),
    .res_sign_a (sign_a_q),
    .res_sign_b (sign_b_q),
    .res_b_zero (b_zero_q),
    .res_raw_a  (raw_a_q),
    .res_acc    (acc_step),
    .res_hi     (fix_hi),
    .res_lo     (fix_lo)
  );

  gnrl_dfflr #(.DW(2)) u_state (
    .clk(clk), .rst(rst), .lden(1'b1), .dnxt(state_d), .qout(state_q));
  gnrl_dfflr #(.DW(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .lden(accept | calc), .dnxt(cnt_d), .qout(cnt_q));
  gnrl_dfflr #(.DW(4)) u_info (
    .clk(clk), .rst(rst), .lden(accept), .dnxt(info_d), .qout(info_q));
  gnrl_dfflr #(.DW(DATA_W)) u_raw_a (
    .clk(clk), .rst(rst), .lden(accept), .dnxt(bus.req_a), .qout(raw_a_q));
  gnrl_dfflr #(.DW(DATA_W)) u_b_abs (
    .clk(clk), .rst(rst), .lden(accept), .dnxt(in_abs_b), .qout(b_abs_q));
  gnrl_dfflr #(.DW(ACC_W)) u_acc (
    .clk(clk), .rst(rst), .lden(accept | calc), .dnxt(acc_d), .qout(acc_q));
  gnrl_dfflr #(.DW(1)) u_wb_valid (
    .clk(clk), .rst(rst), .lden(1'b1), .dnxt(wb_load), .qout(wb_valid_q));
  gnrl_dfflr #(.DW(ACC_W)) u_wb (
    .clk(clk), .rst(rst), .lden(wb_load), .dnxt({fix_hi, fix_lo}), .qout(wb_q));

  assign bus.req_ready = (state_q == ST_IDLE) & ~bus.flush;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_hi     = wb_q[ACC_W-1:DATA_W];
  assign bus.wb_lo     = wb_q[DATA_W-1:0];
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - randomized and directed bench for hilo_muldiv against an arithmetic model
module tb_hilo_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hilo_muldiv_if #(.DATA_W(32)) bus ();
  hilo_muldiv #(.DATA_W(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired, required completion (t=%0t)", name, $time);
  endtask

  // Architectural result {hi, lo} from plain 64-bit integer arithmetic.
  function automatic logic [63:0] ref_muldiv(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      default: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFF_FFFF};
        end else if (op == 2'b11) begin
          r = {ua % ub, 32'd0} | (ua / ub);
          r = {32'(ua % ub), 32'(ua / ub)};
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          r = {sr[31:0], sq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  // Timeline model: accepted at edge N, results visible after edge N+32, idle after N+33.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_res = '0;
  int          m_end = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_hi    <= '0;
      m_lo    <= '0;
    end else begin
      m_valid <= 1'b0;
      if (!m_busy) begin
        if (bus.req_valid && !bus.flush) begin
          m_busy <= 1'b1;
          m_end  <= cyc + 1 + 32;
          m_res  <= ref_muldiv(bus.req_op, bus.req_a, bus.req_b);
        end
      end else if (bus.flush && (cyc + 1 <= m_end)) begin
        m_busy <= 1'b0;
      end else if (cyc + 1 == m_end) begin
        m_valid <= 1'b1;
        m_hi    <= m_res[63:32];
        m_lo    <= m_res[31:0];
      end else if (cyc + 1 > m_end) begin
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    chk("wb_valid", 64'(bus.wb_valid), 64'(m_valid));
    chk("wb_hi", 64'(bus.wb_hi), 64'(m_hi));
    chk("wb_lo", 64'(bus.wb_lo), 64'(m_lo));
    chk("busy", 64'(bus.busy), 64'(m_busy));
    chk("req_ready", 64'(bus.req_ready), 64'(!m_busy && !bus.flush));
  end

  // Holds req_valid until the model says the unit is ready, then optionally flushes
  // for one cycle starting fl cycles after the accept edge.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int fl);
    int guard = 0;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    while ((m_busy || bus.flush) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) bound_expired("accept");
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    if (fl >= 0) begin
      repeat (fl) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (m_busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) bound_expired("idle");
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation bound expired");
    $fatal(1);
  end

  initial begin
    int lat;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.flush     = 1'b0;

    chk("ref_multu", ref_muldiv(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("ref_mult", ref_muldiv(2'b00, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
    chk("ref_div", ref_muldiv(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("ref_div_ovf", ref_muldiv(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    chk("ref_divu_zero", ref_muldiv(2'b11, 32'd100, 32'd0), 64'h0000_0064_FFFF_FFFF);

    repeat (3) @(negedge clk);
    chk("reset_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("reset_wb_hi", 64'(bus.wb_hi), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    lat = 0;
    while (!bus.wb_valid && lat < 40) begin
      @(negedge clk);
      #2;
      lat++;
    end
    chk("multu_latency", 64'(lat), 64'd32);
    wait_idle();
    chk("multu_hi", 64'(bus.wb_hi), 64'h0000_0000_FFFF_FFFE);
    chk("multu_lo", 64'(bus.wb_lo), 64'h0000_0000_0000_0001);

    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, -1);
    wait_idle();
    chk("mult_hi", 64'(bus.wb_hi), 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo", 64'(bus.wb_lo), 64'h0000_0000_FFFF_FFF1);

    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1);
    wait_idle();
    chk("div_hi", 64'(bus.wb_hi), 64'h0000_0000_FFFF_FFFF);
    chk("div_lo", 64'(bus.wb_lo), 64'h0000_0000_FFFF_FFFD);

    do_op(2'b11, 32'd100, 32'd0, -1);
    wait_idle();
    chk("divu_zero_hi", 64'(bus.wb_hi), 64'd100);
    chk("divu_zero_lo", 64'(bus.wb_lo), 64'h0000_0000_FFFF_FFFF);

    do_op(2'b10, 32'hFFFF_FFF0, 32'd0, -1);
    wait_idle();
    chk("div_zero_hi", 64'(bus.wb_hi), 64'h0000_0000_FFFF_FFF0);
    chk("div_zero_lo", 64'(bus.wb_lo), 64'h0000_0000_FFFF_FFFF);

    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    wait_idle();
    chk("div_ovf_hi", 64'(bus.wb_hi), 64'd0);
    chk("div_ovf_lo", 64'(bus.wb_lo), 64'h0000_0000_8000_0000);

    // Flush mid-CALC, then a new op issued as soon as the unit frees up.
    do_op(2'b11, 32'd10, 32'd3, 9);
    do_op(2'b01, 32'd6, 32'd7, -1);
    wait_idle();
    chk("flush_next_hi", 64'(bus.wb_hi), 64'd0);
    chk("flush_next_lo", 64'(bus.wb_lo), 64'd42);

    // Flush landing in the DONE cycle must not suppress the writeback.
    do_op(2'b00, 32'd7, 32'hFFFF_FFFA, 32);
    wait_idle();
    chk("done_flush_hi", 64'(bus.wb_hi), 64'h0000_0000_FFFF_FFFF);
    chk("done_flush_lo", 64'(bus.wb_lo), 64'h0000_0000_FFFF_FFD6);

    // Flush while idle blocks the handshake.
    bus.req_valid = 1'b1;
    bus.flush     = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of CALC.
    do_op(2'b11, 32'd10, 32'd3, -1);
    repeat (10) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_wb_hi", 64'(bus.wb_hi), 64'd0);
    chk("rst_wb_lo", 64'(bus.wb_lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      int fl;
      fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 34)) : -1;
      do_op(2'($urandom_range(0, 3)), pick(), pick(), fl);
    end
    wait_idle();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
Iterative multiply/divide unit that produces the HI/LO results tracked by the HI/LO outstanding-instruction FIFOs. It accepts one MULT/MULTU/DIV/DIVU op from the EX stage, computes it over 32 iterations, then emits a one-cycle writeback pulse carrying both HI and LO. That pulse drives the retire input of the HI/LO tracking FIFOs and the HI/LO register write port. Only one op is in flight at a time; EX stalls on req_ready low.

Parameters:
DATA_W, 32, operand/result width (only 32 is supported)
CNT_W, 6, iteration-counter width; must hold DATA_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  EX presents an op
req_ready  out  1  unit can accept; req_ready = (state==IDLE) & ~flush
req_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
req_a  in  DATA_W  rs operand (dividend / multiplicand)
req_b  in  DATA_W  rt operand (divisor / multiplier)
flush  in  1  pipeline flush (exception/redirect); kills the in-flight op
busy  out  1  state != IDLE
wb_valid  out  1  one-cycle pulse: HI and LO results valid
wb_hi  out  DATA_W  HI result (product upper word / remainder)
wb_lo  out  DATA_W  LO result (product lower word / quotient)

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, wb_valid=0, wb_hi=0, wb_lo=0, busy=0. Reset mid-op abandons the op; no wb_valid follows.
- Accept: on a clock edge where req_valid & req_ready. The edge latches the op, the sign flags and the absolute values of the operands (absolute values only for the signed ops), and moves state to CALC with counter=0.
- CALC: one iteration per cycle. After the 32nd iteration (counter==DATA_W-1), move to DONE.
- DONE: lasts exactly one cycle, during which wb_valid=1 and wb_hi/wb_lo carry the sign-corrected results. The next state is IDLE.
- Latency: accept at edge N gives wb_valid high in cycle N+33. req_ready is high again in cycle N+34.
- Back-to-back ops: the next op can be accepted at the edge that ends the IDLE cycle after DONE. Throughput is 1 op per 34 cycles.
- wb_hi/wb_lo are registered and hold their values after DONE until the next DONE or reset. wb_valid is 1 only in DONE.
- Multiply: shift-add on a 65-bit accumulator {carry, hi, lo}, with lo initialised to |a| and hi to 0.
  - Each iteration: if lo[0]=1, add |b| to hi; then shift the accumulator right by 1.
  - Signed ops: if sign(a) XOR sign(b), negate the 64-bit product (two's complement).
- Divide: restoring divide with a 64-bit {rem, quo} register, initialised to {0, |a|}.
  - Each iteration: shift the register left by 1, trial-subtract |b| from rem; if no borrow, keep the difference and set quo[0]=1.
  - Signed ops: quotient negated if sign(a) XOR sign(b); remainder takes the sign of a.
- Divide by zero (b==0): the op still takes the full 33 cycles. Result: wb_lo=32'hFFFFFFFF and wb_hi=req_a (the raw operand), for both DIV and DIVU.
- Signed overflow 0x80000000 / 0xFFFFFFFF: wb_lo=0x80000000, wb_hi=0. This falls out of the algorithm with no special case.
- Flush:
  - In CALC: state becomes IDLE at the next edge and no wb_valid is produced.
  - In DONE: ignored; the writeback still completes.
  - In IDLE: req_ready is 0, so no accept happens that cycle.
- req_valid while busy is ignored. EX must hold req_valid until the handshake completes.

Decomposition:
- The shared defines header holds:
  - op encodings (`MulDivMult=2'b00, `MulDivMultu=2'b01, `MulDivDiv=2'b10, `MulDivDivu=2'b11)
  - `MulDivOpBus
  - the state encodings (IDLE=2'b00, CALC=2'b01, DONE=2'b10)
- Registers use the codebase's generic enable flop cells (gnrl_dfflr style), adapted to the active-high async reset.
- One sub-module is natural: muldiv_signfix. It is combinational and performs absolute value on entry and result negation/sign correction on exit. The FSM, counter and iteration datapath stay in hilo_muldiv.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, accepted at edge N -> wb_valid high only in cycle N+33; wb_hi=0xFFFFFFFE, wb_lo=0x00000001; req_ready back at N+34.
- MULT a=0xFFFFFFFD (-3), b=5 -> wb_hi=0xFFFFFFFF, wb_lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> wb_lo=0xFFFFFFFD, wb_hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> wb_lo=0xFFFFFFFF, wb_hi=100 after 33 cycles. DIV a=0x80000000, b=0xFFFFFFFF -> wb_lo=0x80000000, wb_hi=0.
- DIVU 10/3 accepted, flush asserted in cycle N+10 -> no wb_valid ever; req_ready=1 in cycle N+11; a new MULTU 6*7 accepted there -> wb_lo=42, wb_hi=0, 33 cycles later.
- rst asserted mid-CALC -> all outputs 0 immediately (async); no wb_valid after release. A flush during DONE -> wb_valid still pulses with the correct result.
